// File: rtl/id_exe_stage_reg_pkg.sv
// Shared ARM-subset pipeline constants.
// Holds the field widths used by every pipeline register, the ALU command
// encodings carried on exe_cmd, and the bit positions inside the NZCV word.
package id_exe_stage_reg_pkg;

    // Field widths
    localparam int ARM_DATA_W      = 32;
    localparam int ARM_REG_W       = 4;
    localparam int SHIFT_OPERAND_W = 12;
    localparam int SIGNED_IMM_W    = 24;
    localparam int EXE_CMD_W       = 4;
    localparam int STATUS_W        = 4;

    // ALU command encodings; EXE_NOP is also what a bubble carries
    typedef enum logic [EXE_CMD_W-1:0] {
        EXE_NOP = 4'b0000,
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_e;

    // NZCV bit positions
    localparam int STATUS_N = 3;
    localparam int STATUS_Z = 2;
    localparam int STATUS_C = 1;
    localparam int STATUS_V = 0;

    // Assembles an NZCV word from individual flags
    function automatic logic [STATUS_W-1:0] pack_nzcv(input logic n, input logic z,
                                                      input logic c, input logic v);
        logic [STATUS_W-1:0] w;
        w           = '0;
        w[STATUS_N] = n;
        w[STATUS_Z] = z;
        w[STATUS_C] = c;
        w[STATUS_V] = v;
        return w;
    endfunction

endpackage

// File: rtl/id_exe_stage_reg_status_register.sv
// Architectural NZCV status register.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset, clears the flags
//   freeze - memory stall, holds the flags even if we is high
//   we     - write enable from EXE (instruction with S=1)
//   d      - new NZCV from the EXE ALU
//   q      - current NZCV
module status_register
    import id_exe_stage_reg_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                we,
    input  logic [STATUS_W-1:0] d,
    output logic [STATUS_W-1:0] q
);

    // The writer is the instruction already in EXE, so flush/hazard never
    // block an update; only a freeze does.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (!freeze && we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register plus the NZCV status register.
// Captures decoded controls and operands from ID every cycle, loads a bubble
// on a taken-branch flush or a load-use hazard, and holds everything on freeze.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   freeze, flush, hazard    - stall / kill / bubble requests (that priority)
//   *_in                     - decoded fields from ID
//   exe_*                    - registered copies of the *_in fields
//   exe_valid                - slot holds a real instruction
//   status_we, status_in     - NZCV write from EXE
//   status                   - current NZCV
module id_exe_stage_reg
    import id_exe_stage_reg_pkg::*;
#(
    parameter int DATA_W = ARM_DATA_W,
    parameter int REG_W  = ARM_REG_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       flush,
    input  logic                       hazard,

    input  logic                       wb_en_in,
    input  logic                       mem_r_en_in,
    input  logic                       mem_w_en_in,
    input  logic                       b_in,
    input  logic                       s_in,
    input  logic [EXE_CMD_W-1:0]       exe_cmd_in,
    input  logic [DATA_W-1:0]          pc_in,
    input  logic [DATA_W-1:0]          val_rn_in,
    input  logic [DATA_W-1:0]          val_rm_in,
    input  logic                       imm_in,
    input  logic [SHIFT_OPERAND_W-1:0] shift_operand_in,
    input  logic [SIGNED_IMM_W-1:0]    signed_imm_24_in,
    input  logic [REG_W-1:0]           dest_in,
    input  logic [REG_W-1:0]           src1_in,
    input  logic [REG_W-1:0]           src2_in,

    input  logic                       status_we,
    input  logic [STATUS_W-1:0]        status_in,

    output logic                       exe_wb_en,
    output logic                       exe_mem_r_en,
    output logic                       exe_mem_w_en,
    output logic                       exe_b,
    output logic                       exe_s,
    output logic [EXE_CMD_W-1:0]       exe_exe_cmd,
    output logic [DATA_W-1:0]          exe_pc,
    output logic [DATA_W-1:0]          exe_val_rn,
    output logic [DATA_W-1:0]          exe_val_rm,
    output logic                       exe_imm,
    output logic [SHIFT_OPERAND_W-1:0] exe_shift_operand,
    output logic [SIGNED_IMM_W-1:0]    exe_signed_imm_24,
    output logic [REG_W-1:0]           exe_dest,
    output logic [REG_W-1:0]           exe_src1,
    output logic [REG_W-1:0]           exe_src2,
    output logic                       exe_valid,
    output logic [STATUS_W-1:0]        status
);

    // Priority rst > freeze > flush > hazard > load. Freeze simply makes no
    // assignment. A bubble zeroes every field, so exe_dest reads R0 with
    // mem_r_en low and can never trigger a false load-use match. hazard only
    // reaches D-inputs here, which keeps the hazard unit loop registered.
    always_ff @(posedge clk) begin
        if (rst || (!freeze && (flush || hazard))) begin
            exe_wb_en         <= 1'b0;
            exe_mem_r_en      <= 1'b0;
            exe_mem_w_en      <= 1'b0;
            exe_b             <= 1'b0;
            exe_s             <= 1'b0;
            exe_exe_cmd       <= EXE_NOP;
            exe_pc            <= '0;
            exe_val_rn        <= '0;
            exe_val_rm        <= '0;
            exe_imm           <= 1'b0;
            exe_shift_operand <= '0;
            exe_signed_imm_24 <= '0;
            exe_dest          <= '0;
            exe_src1          <= '0;
            exe_src2          <= '0;
            exe_valid         <= 1'b0;
        end else if (!freeze) begin
            exe_wb_en         <= wb_en_in;
            exe_mem_r_en      <= mem_r_en_in;
            exe_mem_w_en      <= mem_w_en_in;
            exe_b             <= b_in;
            exe_s             <= s_in;
            exe_exe_cmd       <= exe_cmd_in;
            exe_pc            <= pc_in;
            exe_val_rn        <= val_rn_in;
            exe_val_rm        <= val_rm_in;
            exe_imm           <= imm_in;
            exe_shift_operand <= shift_operand_in;
            exe_signed_imm_24 <= signed_imm_24_in;
            exe_dest          <= dest_in;
            exe_src1          <= src1_in;
            exe_src2          <= src2_in;
            exe_valid         <= 1'b1;
        end
    end

    status_register u_status_register (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .we     (status_we),
        .d      (status_in),
        .q      (status)
    );

endmodule

// File: doc/id_exe_stage_reg.md
# id_exe_stage_reg

Pipeline register between the ID and EXE stages of the ARM-subset 5-stage core, plus the architectural NZCV status register. It captures decoded control and operand fields from ID each cycle and inserts a bubble when the hazard detection unit flags a load-use dependency. It clears on a taken branch and holds when the memory system freezes the pipe. Its `exe_mem_r_en` / `exe_dest` outputs close the loop back into hazard detection.

## Interface
Parameters:
- `DATA_W`, 32, width of PC and register operands
- `REG_W`, 4, register index width

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high
- `freeze` in 1: memory stall; hold all state
- `flush` in 1: branch taken in EXE; kill the instruction entering EXE
- `hazard` in 1: load-use stall from hazard detection; insert bubble
- `wb_en_in`, `mem_r_en_in`, `mem_w_en_in`, `b_in`, `s_in` in 1 each: decoded controls
- `exe_cmd_in` in 4: ALU command
- `pc_in`, `val_rn_in`, `val_rm_in` in DATA_W: PC+4 and read operands
- `imm_in` in 1; `shift_operand_in` in 12; `signed_imm_24_in` in 24
- `dest_in`, `src1_in`, `src2_in` in REG_W
- `status_we` in 1: EXE asserts when the executing instruction has S=1
- `status_in` in 4: NZCV computed by EXE ALU
- All `*_in` fields mirrored as outputs `exe_*` (same widths), registered
- `exe_valid` out 1: registered slot holds a real instruction
- `status` out 4: current NZCV, to ID condition check and EXE carry-in

## Operation
- Per-cycle priority on the rising edge: `rst` > `freeze` > `flush` > `hazard` > normal load.
- `rst`: every output and `status` to 0, including `exe_valid`.
- `freeze`: all registers, including `status`, hold their value. A simultaneous `flush`, `hazard` or `status_we` has no effect that cycle. The source asserting it re-presents the signal after the freeze.
- `flush`, no freeze: the register loads a bubble.
- `hazard`, no freeze or flush: the register loads a bubble.
- Bubble:
  - `wb_en`, `mem_r_en`, `mem_w_en`, `b`, `s` and `exe_valid` = 0.
  - `exe_cmd` = 0, `dest` = 0.
  - Data fields = 0, so `exe_dest` cannot falsely match in hazard detection beyond R0. R0 with `mem_r_en`=0 is never a hazard.
- Normal load: every field is captured from its `*_in` input; `exe_valid` = 1.
- Status register:
  - Updates to `status_in` when `status_we`=1 and `freeze`=0.
  - It is independent of `flush` and `hazard`, because the EXE instruction that writes it is older than the one being killed.
- `exe_src1` / `exe_src2` are carried through for the forwarding unit. They follow the same bubble and hold rules.

## Timing
- Latency: 1 cycle from ID inputs to `exe_*` outputs.
- Hazard path: `hazard` high in cycle N. EXE sees a bubble in N+1 while IF/ID holds (upstream responsibility). The stalled instruction is captured in N+1 once `hazard` drops.
- `hazard` is combinational from current `exe_*` outputs. This block must not combinationally depend on `hazard` except at its D-inputs, so no loop exists.
- `status` written at edge N is visible to ID condition evaluation in cycle N+1.
- `rst` mid-freeze: reset wins. All outputs are 0 the next cycle.

## Structure
- Shared ARM pipeline constants header holds:
  - field widths (`DATA_W`, `REG_W`, 12/24-bit immediates)
  - EXE_CMD encodings
  - NZCV bit positions (N=3, Z=2, C=1, V=0)
- One sub-module, `status_register`:
  - 4-bit register with `clk`, `rst`, `freeze`, `we`, `d`, `q`
  - instantiated once
- The rest is a single clocked process with the priority chain above.

## Test plan
- Reset: drive all inputs to 1 and pulse `rst` for 2 cycles. All `exe_*`, `exe_valid` and `status` read 0.
- Normal load:
  - Inputs: `pc_in`=0x10, `dest_in`=3, `mem_r_en_in`=1, `exe_cmd_in`=0b0010.
  - Next cycle outputs match exactly; `exe_valid`=1.
- Load-use bubble:
  - Cycle N: `hazard`=1 with `wb_en_in`=1, `dest_in`=5.
  - N+1: `exe_wb_en`=0, `exe_dest`=0, `exe_valid`=0.
  - Drop `hazard`; N+2 captures `dest`=5.
- Freeze dominance:
  - Load `dest`=7, then assert `freeze` with `flush`=1, `hazard`=1, `status_we`=1 and `status_in`=0xF for 3 cycles.
  - Outputs stay `dest`=7; `status` is unchanged.
- Flush with status:
  - Same cycle: `flush`=1, `status_we`=1, `status_in`=0b0100.
  - Next cycle: bubble in EXE and `status`=0b0100.
- Reset during freeze: `freeze`=1 and `rst`=1 together. All outputs read 0 next cycle.
